// File: rtl/rwm_sequencer.sv
// Command-driven sequencer for the frame R/W memory: clear, capture-write and
// readout requests with per-operation watchdog, readout length check and frame counter.
module rwm_sequencer #(
  parameter int N       = 5,
  parameter int M       = 5,
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  input  logic       err_clr,
  input  logic       RWM_done,
  input  logic       RWM_valid,
  output logic       RWM_enable,
  output logic       rw,
  output logic       clear,
  output logic       busy,
  output logic       op_done,
  output logic       op_err,
  output logic [1:0] err_code,
  output logic [7:0] frame_cnt
);

  localparam int RD_W = $clog2(N*M+1);
  localparam int WD_W = $clog2(TIMEOUT+1);
  localparam logic [RD_W-1:0] RD_MAX     = {RD_W{1'b1}};
  localparam logic [RD_W-1:0] FRAME_SIZE = RD_W'(N*M);
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT-1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLR_REQ  = 3'd1,
    ST_CLR_WAIT = 3'd2,
    ST_WR_REQ   = 3'd3,
    ST_WR_WAIT  = 3'd4,
    ST_RD_REQ   = 3'd5,
    ST_RD_WAIT  = 3'd6,
    ST_ERROR    = 3'd7
  } state_t;

  state_t          state_r;
  logic [1:0]      op_r;
  logic [RD_W-1:0] rd_cnt_r;
  logic [RD_W-1:0] rd_nxt_s;
  logic [WD_W-1:0] wd_cnt_r;
  logic            cmd_ready_r;
  logic            rwm_enable_r;
  logic            rw_r;
  logic            clear_r;
  logic            busy_r;
  logic            op_done_r;
  logic            op_err_r;
  logic [1:0]      err_code_r;
  logic [7:0]      frame_cnt_r;

  // Readout byte count including the current cycle, saturating at all-ones
  always_comb begin
    rd_nxt_s = rd_cnt_r;
    if ((state_r == ST_RD_WAIT) && RWM_valid && (rd_cnt_r != RD_MAX)) begin
      rd_nxt_s = rd_cnt_r + 1'b1;
    end else begin
      rd_nxt_s = rd_cnt_r;
    end
  end

  // Sequencer FSM; every output is set on the edge that enters its state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      op_r         <= 2'b00;
      rd_cnt_r     <= {RD_W{1'b0}};
      wd_cnt_r     <= {WD_W{1'b0}};
      cmd_ready_r  <= 1'b1;
      rwm_enable_r <= 1'b0;
      rw_r         <= 1'b0;
      clear_r      <= 1'b0;
      busy_r       <= 1'b0;
      op_done_r    <= 1'b0;
      op_err_r     <= 1'b0;
      err_code_r   <= 2'b00;
      frame_cnt_r  <= 8'd0;
    end else begin
      op_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (RWM_done) begin
            state_r     <= ST_ERROR;
            err_code_r  <= 2'b11;
            op_err_r    <= 1'b1;
            cmd_ready_r <= 1'b0;
          end else if (cmd_valid) begin
            op_r         <= cmd_op;
            cmd_ready_r  <= 1'b0;
            busy_r       <= 1'b1;
            rwm_enable_r <= 1'b1;
            case (cmd_op)
              2'b01: begin
                state_r <= ST_WR_REQ;
                rw_r    <= 1'b1;
                clear_r <= 1'b0;
              end
              2'b10: begin
                state_r <= ST_RD_REQ;
                rw_r    <= 1'b0;
                clear_r <= 1'b0;
              end
              default: begin
                state_r <= ST_CLR_REQ;
                rw_r    <= 1'b0;
                clear_r <= 1'b1;
              end
            endcase
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CLR_REQ, ST_WR_REQ, ST_RD_REQ: begin
          // Done pulses during a request cycle are deliberately ignored
          rwm_enable_r <= 1'b0;
          clear_r      <= 1'b0;
          wd_cnt_r     <= {WD_W{1'b0}};
          rd_cnt_r     <= {RD_W{1'b0}};
          case (state_r)
            ST_CLR_REQ: state_r <= ST_CLR_WAIT;
            ST_WR_REQ:  state_r <= ST_WR_WAIT;
            default:    state_r <= ST_RD_WAIT;
          endcase
        end
        ST_CLR_WAIT, ST_WR_WAIT, ST_RD_WAIT: begin
          rd_cnt_r <= rd_nxt_s;
          if (RWM_done) begin
            if (state_r == ST_WR_WAIT) begin
              frame_cnt_r <= frame_cnt_r + 8'd1;
            end else begin
              frame_cnt_r <= frame_cnt_r;
            end
            if ((state_r == ST_RD_WAIT) && (rd_nxt_s != FRAME_SIZE)) begin
              state_r    <= ST_ERROR;
              err_code_r <= 2'b10;
              op_err_r   <= 1'b1;
              busy_r     <= 1'b0;
            end else if ((state_r != ST_RD_WAIT) && (op_r == 2'b11)) begin
              // Full cycle chains into the next phase with its own request
              rwm_enable_r <= 1'b1;
              if (state_r == ST_CLR_WAIT) begin
                state_r <= ST_WR_REQ;
                rw_r    <= 1'b1;
              end else begin
                state_r <= ST_RD_REQ;
                rw_r    <= 1'b0;
              end
            end else begin
              state_r     <= ST_IDLE;
              op_done_r   <= 1'b1;
              busy_r      <= 1'b0;
              cmd_ready_r <= 1'b1;
            end
          end else if (wd_cnt_r == WD_LAST) begin
            state_r    <= ST_ERROR;
            err_code_r <= 2'b01;
            op_err_r   <= 1'b1;
            busy_r     <= 1'b0;
          end else begin
            wd_cnt_r <= wd_cnt_r + 1'b1;
          end
        end
        ST_ERROR: begin
          if (err_clr) begin
            state_r     <= ST_IDLE;
            err_code_r  <= 2'b00;
            op_err_r    <= 1'b0;
            cmd_ready_r <= 1'b1;
          end else begin
            state_r <= ST_ERROR;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          cmd_ready_r  <= 1'b1;
          rwm_enable_r <= 1'b0;
          clear_r      <= 1'b0;
          busy_r       <= 1'b0;
          op_err_r     <= 1'b0;
          err_code_r   <= 2'b00;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_r;
  assign RWM_enable = rwm_enable_r;
  assign rw         = rw_r;
  assign clear      = clear_r;
  assign busy       = busy_r;
  assign op_done    = op_done_r;
  assign op_err     = op_err_r;
  assign err_code   = err_code_r;
  assign frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_rwm_sequencer.sv
// Directed self-checking bench for rwm_sequencer; the bench plays the memory side.
module tb_rwm_sequencer;

  localparam int TIMEOUT = 1024;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;
  logic       err_clr;
  logic       RWM_done;
  logic       RWM_valid;
  logic       RWM_enable;
  logic       rw;
  logic       clear;
  logic       busy;
  logic       op_done;
  logic       op_err;
  logic [1:0] err_code;
  logic [7:0] frame_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_seen = 0;
  int en_seen = 0;
  logic [7:0] exp_frame = 8'd0;

  rwm_sequencer #(.N(5), .M(5), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .err_clr(err_clr), .RWM_done(RWM_done),
    .RWM_valid(RWM_valid), .RWM_enable(RWM_enable), .rw(rw), .clear(clear),
    .busy(busy), .op_done(op_done), .op_err(op_err), .err_code(err_code),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and sample 1 time unit after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
    if (op_done === 1'b1) done_seen++;
    if (RWM_enable === 1'b1) en_seen++;
  endtask

  task automatic send(input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_op = op;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; err_clr = 1'b0;
    RWM_done = 1'b0; RWM_valid = 1'b0;
    #12;
    total_cnt++;
    if ({RWM_enable, rw, clear, busy, op_done, op_err, err_code, frame_cnt} !== 15'd0)
      $display("FAIL reset_outputs: got en%b rw%b clr%b busy%b done%b err%b code%b fc%0d want all 0",
               RWM_enable, rw, clear, busy, op_done, op_err, err_code, frame_cnt);
    else pass_cnt++;
    rst_n = 1'b1;
    cyc();
    total_cnt++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) $display("FAIL reset_ready: ready=%b busy=%b want 1/0", cmd_ready, busy);
    else pass_cnt++;
  endtask

  task automatic test_capture();
    done_seen = 0; en_seen = 0;
    send(2'b01);
    total_cnt++;
    if (RWM_enable !== 1'b1 || rw !== 1'b1 || clear !== 1'b0 || busy !== 1'b1)
      $display("FAIL cap_req: en=%b rw=%b clr=%b busy=%b want 1/1/0/1", RWM_enable, rw, clear, busy);
    else pass_cnt++;
    for (int i = 1; i < 25; i++) cyc();
    RWM_done = 1'b1;
    cyc();
    RWM_done = 1'b0;
    exp_frame = exp_frame + 8'd1;
    total_cnt++;
    if (op_done !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0 || frame_cnt !== exp_frame)
      $display("FAIL cap_done: done=%b ready=%b busy=%b fc=%0d want 1/1/0/%0d", op_done, cmd_ready, busy, frame_cnt, exp_frame);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (op_done !== 1'b0 || done_seen !== 1 || en_seen !== 1 || rw !== 1'b1)
      $display("FAIL cap_pulses: done=%b done_seen=%0d en_seen=%0d rw=%b want 0/1/1/1", op_done, done_seen, en_seen, rw);
    else pass_cnt++;
  endtask

  task automatic test_readout(input int nvalid);
    done_seen = 0;
    send(2'b10);
    total_cnt++;
    if (RWM_enable !== 1'b1 || rw !== 1'b0) $display("FAIL rd_req: en=%b rw=%b want 1/0", RWM_enable, rw);
    else pass_cnt++;
    cyc();
    for (int i = 1; i <= 25; i++) begin
      RWM_valid = (i > 25 - nvalid);
      RWM_done = (i == 25);
      cyc();
    end
    RWM_valid = 1'b0; RWM_done = 1'b0;
    total_cnt++;
    if (nvalid == 25) begin
      if (op_done !== 1'b1 || op_err !== 1'b0 || err_code !== 2'b00)
        $display("FAIL rd_ok: done=%b err=%b code=%b want 1/0/00", op_done, op_err, err_code);
      else pass_cnt++;
    end else begin
      if (op_done !== 1'b0 || op_err !== 1'b1 || err_code !== 2'b10 || busy !== 1'b0 || cmd_ready !== 1'b0)
        $display("FAIL rd_short: done=%b err=%b code=%b busy=%b ready=%b want 0/1/10/0/0", op_done, op_err, err_code, busy, cmd_ready);
      else pass_cnt++;
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      total_cnt++;
      if (cmd_ready !== 1'b1 || op_err !== 1'b0 || err_code !== 2'b00)
        $display("FAIL rd_errclr: ready=%b err=%b code=%b want 1/0/00", cmd_ready, op_err, err_code);
      else pass_cnt++;
    end
  endtask

  task automatic test_full_cycle();
    done_seen = 0;
    send(2'b11);
    total_cnt++;
    if (RWM_enable !== 1'b1 || clear !== 1'b1 || rw !== 1'b0) $display("FAIL full_clr_req: en=%b clr=%b rw=%b want 1/1/0", RWM_enable, clear, rw);
    else pass_cnt++;
    cyc();
    RWM_done = 1'b1;
    cyc();
    RWM_done = 1'b0;
    total_cnt++;
    if (RWM_enable !== 1'b1 || rw !== 1'b1 || clear !== 1'b0 || busy !== 1'b1 || op_done !== 1'b0)
      $display("FAIL full_wr_req: en=%b rw=%b clr=%b busy=%b done=%b want 1/1/0/1/0", RWM_enable, rw, clear, busy, op_done);
    else pass_cnt++;
    cyc();
    RWM_done = 1'b1;
    cyc();
    RWM_done = 1'b0;
    exp_frame = exp_frame + 8'd1;
    total_cnt++;
    if (RWM_enable !== 1'b1 || rw !== 1'b0 || busy !== 1'b1 || op_done !== 1'b0 || frame_cnt !== exp_frame)
      $display("FAIL full_rd_req: en=%b rw=%b busy=%b done=%b fc=%0d want 1/0/1/0/%0d", RWM_enable, rw, busy, op_done, frame_cnt, exp_frame);
    else pass_cnt++;
    cyc();
    for (int i = 1; i <= 25; i++) begin
      RWM_valid = 1'b1;
      RWM_done = (i == 25);
      cyc();
    end
    RWM_valid = 1'b0; RWM_done = 1'b0;
    cyc();
    total_cnt++;
    if (done_seen !== 1 || op_err !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL full_done: done_seen=%0d err=%b ready=%b want 1/0/1", done_seen, op_err, cmd_ready);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int n;
    send(2'b01);
    cyc();
    n = 0;
    while (op_err !== 1'b1 && n < 2 * TIMEOUT) begin
      cyc();
      n++;
    end
    total_cnt++;
    if (n !== TIMEOUT || err_code !== 2'b01 || busy !== 1'b0)
      $display("FAIL timeout: cycles=%0d code=%b busy=%b want %0d/01/0", n, err_code, busy, TIMEOUT);
    else pass_cnt++;
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    total_cnt++;
    if (cmd_ready !== 1'b1 || err_code !== 2'b00 || op_err !== 1'b0 || frame_cnt !== exp_frame)
      $display("FAIL timeout_clr: ready=%b code=%b err=%b fc=%0d want 1/00/0/%0d", cmd_ready, err_code, op_err, frame_cnt, exp_frame);
    else pass_cnt++;
  endtask

  task automatic test_spurious_done();
    RWM_done = 1'b1;
    cyc();
    RWM_done = 1'b0;
    total_cnt++;
    if (op_err !== 1'b1 || err_code !== 2'b11 || cmd_ready !== 1'b0)
      $display("FAIL spurious: err=%b code=%b ready=%b want 1/11/0", op_err, err_code, cmd_ready);
    else pass_cnt++;
    en_seen = 0;
    cmd_valid = 1'b1; cmd_op = 2'b01;
    for (int i = 0; i < 5; i++) cyc();
    total_cnt++;
    if (en_seen !== 0 || busy !== 1'b0 || op_err !== 1'b1)
      $display("FAIL err_hold: en_seen=%0d busy=%b err=%b want 0/0/1", en_seen, busy, op_err);
    else pass_cnt++;
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0; cmd_valid = 1'b0;
    total_cnt++;
    if (cmd_ready !== 1'b1 || RWM_enable !== 1'b0 || busy !== 1'b0 || err_code !== 2'b00)
      $display("FAIL err_clr_cmd: ready=%b en=%b busy=%b code=%b want 1/0/0/00", cmd_ready, RWM_enable, busy, err_code);
    else pass_cnt++;
    cyc();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 256; k++) begin
      send(2'b01);
      RWM_done = 1'b1;
      cyc();
      cyc();
      RWM_done = 1'b0;
      exp_frame = exp_frame + 8'd1;
      if (exp_frame == 8'd0) begin
        total_cnt++;
        if (frame_cnt !== 8'd0 || op_done !== 1'b1) $display("FAIL wrap: fc=%0d done=%b want 0/1", frame_cnt, op_done);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (frame_cnt !== exp_frame) $display("FAIL wrap_end: fc=%0d want %0d", frame_cnt, exp_frame);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    send(2'b01);
    cyc();
    cyc();
    done_seen = 0;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({RWM_enable, rw, clear, busy, op_done, op_err, err_code, frame_cnt} !== 15'd0)
      $display("FAIL reset_mid: en%b rw%b clr%b busy%b done%b err%b code%b fc%0d want all 0",
               RWM_enable, rw, clear, busy, op_done, op_err, err_code, frame_cnt);
    else pass_cnt++;
    #3;
    rst_n = 1'b1;
    exp_frame = 8'd0;
    for (int i = 0; i < 4; i++) cyc();
    total_cnt++;
    if (done_seen !== 0 || cmd_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_mid_after: done_seen=%0d ready=%b busy=%b want 0/1/0", done_seen, cmd_ready, busy);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_readout(25);
    test_readout(24);
    test_full_cycle();
    test_timeout();
    test_spurious_done();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rwm_sequencer.md
# rwm_sequencer

Command-driven controller that sequences the frame R/W memory (clear, capture-write, readout) on behalf of the top-level control path. It accepts one command at a time, issues the single-cycle enable/rw/clear request the memory samples in its idle state, and watches the memory's done/valid status. It enforces a per-operation watchdog, checks the readout length against the frame size, and keeps a captured-frame counter.

## Interface
Parameters:
- N, 5, image height in pixels
- M, 5, image width in pixels
- TIMEOUT, 1024, max cycles in a wait state before a timeout error (≥ N*M+2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_op  in  2  00 clear, 01 capture, 10 readout, 11 full cycle (clear→capture→readout)
- cmd_ready  out  1  high only in IDLE
- err_clr  in  1  leaves ERROR
- RWM_done  in  1  memory operation complete (one-cycle pulse)
- RWM_valid  in  1  memory output byte valid
- RWM_enable  out  1  memory request strobe
- rw  out  1  0 read, 1 write
- clear  out  1  clear request
- busy  out  1  high in any state except IDLE/ERROR
- op_done  out  1  one-cycle pulse at command completion
- op_err  out  1  high in ERROR
- err_code  out  2  01 timeout, 10 read-length mismatch, 11 spurious done
- frame_cnt  out  8  completed captures, wraps 255→0

## Operation
- States: IDLE, CLR_REQ, CLR_WAIT, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, ERROR. All outputs registered.
- IDLE: cmd_valid & cmd_ready at an edge accepts cmd_op; op 00/11 → CLR_REQ, 01 → WR_REQ, 10 → RD_REQ.
- *_REQ (one cycle): RWM_enable=1; clear=1 only in CLR_REQ; rw=1 in WR_REQ, 0 otherwise. Always advances to matching *_WAIT.
- *_WAIT: RWM_enable=0, clear=0; rw held at request value. On RWM_done:
  - CLR_WAIT: op 00 → IDLE + op_done; op 11 → WR_REQ.
  - WR_WAIT: frame_cnt+1; op 01 → IDLE + op_done; op 11 → RD_REQ.
  - RD_WAIT: rd_cnt == N*M → IDLE + op_done; otherwise → ERROR, err_code=10.
- rd_cnt: cleared on entering RD_WAIT; counts cycles with RWM_valid=1 in RD_WAIT, including the RWM_done cycle. Width ceil(log2(N*M+1)); saturates.
- Watchdog: wd_cnt cleared on entering any *_WAIT, increments each WAIT cycle without RWM_done; reaching TIMEOUT → ERROR, err_code=01. RWM_done on the same cycle wins.
- RWM_done observed in IDLE → ERROR, err_code=11. Ignored in *_REQ.
- ERROR: cmd_ready=0, op_err=1, err_code held; err_clr → IDLE, err_code←00. A command presented with err_clr is not accepted.
- frame_cnt never cleared except by reset.

## Timing
- Reset (async, any state): state IDLE; RWM_enable, rw, clear, busy, op_done, op_err=0; err_code=00; frame_cnt=0; cmd_ready=1 on the first cycle after release. A reset mid-operation abandons the memory operation; no op_done is issued.
- Accept edge T: RWM_enable=1 during T+1, 0 from T+2; busy=1 from T+1.
- RWM_done at edge D in the final WAIT: op_done=1 and cmd_ready=1 during D+1; busy=0 during D+1. New command acceptable at D+1 edge.
- Full cycle: op_done once, after the readout done only; busy stays high between phases; each phase has its own one-cycle REQ.
- Minimum command-to-done latency: 3 cycles (done on the first WAIT cycle).

## Test plan
- Reset, then cmd_op=01 with memory model giving RWM_done 25 cycles after enable → single RWM_enable pulse with rw=1, op_done 1 cycle after done, frame_cnt=1.
- cmd_op=10, model asserts RWM_valid for 25 cycles with done on the 25th → op_done, no error; repeat with 24 valid cycles → op_err=1, err_code=10.
- cmd_op=11 → three REQ pulses in order clear(clear=1), write(rw=1), read(rw=0); exactly one op_done at end; frame_cnt+1.
- Model never returns done → op_err=1, err_code=01 after TIMEOUT wait cycles; err_clr → IDLE, cmd_ready=1, err_code=00.
- RWM_done pulsed in IDLE → err_code=11; cmd_valid held during ERROR is not accepted until err_clr.
- 256 captures → frame_cnt wraps to 0; rst_n pulsed during WR_WAIT → all outputs at reset values, no op_done.
